// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// producers. Each granted byte is pulsed into the UART, the arbiter waits
// for the UART to report busy (bounded by BUSY_TIMEOUT), then waits for it
// to go idle before the next grant.
// Optional build macro: ARB_LOCK_EN (req_lock keeps the grant on the last
// requester so multi-byte messages are not interleaved).
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 start_err,
    output logic [15:0]          tx_count
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam logic [2:0] LAST_INIT   = 3'(NUM_REQ - 1);
    localparam logic [7:0] TMO_LIMIT   = 8'(BUSY_TIMEOUT);

    logic [1:0]         state_q, state_d;
    logic [2:0]         last_q, last_d;
    logic [2:0]         grant_q, grant_d;
    logic [7:0]         byte_q, byte_d;
    logic               xmit_q, xmit_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [15:0]        count_q, count_d;
    logic               busy_q, busy_d;

    // Requests and bytes padded to the full 3-bit index space so the
    // arbiter can index them directly with a grant index.
    logic [7:0] req_pad;
    logic [7:0] byte_arr [8];

    assign req_pad = 8'(req);

    for (genvar g = 0; g < 8; g++) begin : g_pad
        if (g < NUM_REQ) begin : g_on
            assign byte_arr[g] = req_byte[8*g +: 8];
        end else begin : g_off
            assign byte_arr[g] = '0;
        end
    end

`ifdef ARB_LOCK_EN
    logic [7:0] lock_pad;
    assign lock_pad = 8'(req_lock);
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    logic       win_valid;
    logic [2:0] win_idx;
    logic [3:0] sum;
    logic [2:0] cand;

    // Pick the winner: first set request searching upward from last+1, wrapping
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
`ifdef ARB_LOCK_EN
        if (req_pad[last_q] && lock_pad[last_q]) begin
            win_valid = 1'b1;
            win_idx   = last_q;
        end
`endif
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            // last_q < NUM_REQ and k <= NUM_REQ, so one subtraction wraps
            sum  = {1'b0, last_q} + 4'(k);
            cand = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
            if (!win_valid && req_pad[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and output logic for the grant / send / wait sequence
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        xmit_d  = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (win_valid && !uart_is_transmitting) begin
                    byte_d  = byte_arr[win_idx];
                    grant_d = win_idx;
                    last_d  = win_idx;
                    xmit_d  = 1'b1;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        ack_d[i] = (3'(i) == win_idx);
                    end
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_is_transmitting) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TMO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; asynchronous reset idles the arbiter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= LAST_INIT;
            grant_q <= '0;
            byte_q  <= '0;
            xmit_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            xmit_q  <= xmit_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ack       = ack_q;
    assign uart_transmit = xmit_q;
    assign uart_tx_byte  = byte_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign start_err     = err_q;
    assign tx_count      = count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with a transaction-level reference model
// compared every cycle, a behavioural UART stub and literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 15;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_byte;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ-1:0]   req_ack;
    logic              uart_transmit;
    logic [7:0]        uart_tx_byte;
    logic              uart_is_transmitting;
    logic [2:0]        grant_id;
    logic              busy;
    logic              start_err;
    logic [15:0]       tx_count;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(TMO)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req                  (req),
        .req_byte             (req_byte),
        .req_lock             (req_lock),
        .req_ack              (req_ack),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .grant_id             (grant_id),
        .busy                 (busy),
        .start_err            (start_err),
        .tx_count             (tx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_active;
    bit              m_seen;
    int              m_age;
    int              m_last;
    logic [7:0]      e_byte;
    logic [2:0]      e_grant;
    logic [15:0]     e_cnt;
    logic            e_xmit;
    logic            e_err;
    logic [NREQ-1:0] e_ack;

    function automatic int pick(input logic [NREQ-1:0] r, input logic [NREQ-1:0] lk, input int last);
        int c;
`ifdef ARB_LOCK_EN
        if (r[last] && lk[last]) return last;
`else
        if (lk === 'x) return -1;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            c = (last + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    initial begin : model_cmp
        logic [NREQ-1:0]   s_req;
        logic [NREQ-1:0]   s_lock;
        logic [8*NREQ-1:0] s_byte;
        logic              s_busy;
        logic              s_rst;
        int                w;
        forever begin
            @(posedge clk);
            s_req  = req;
            s_lock = req_lock;
            s_byte = req_byte;
            s_busy = uart_is_transmitting;
            s_rst  = rst_n;
            e_xmit = 1'b0;
            e_err  = 1'b0;
            e_ack  = '0;
            if (!s_rst) begin
                m_active = 0;
                m_seen   = 0;
                m_age    = 0;
                m_last   = NREQ - 1;
                e_byte   = '0;
                e_grant  = '0;
                e_cnt    = '0;
            end else if (!m_active) begin
                if (s_req != 0 && !s_busy) begin
                    w        = pick(s_req, s_lock, m_last);
                    e_byte   = s_byte[8*w +: 8];
                    e_grant  = 3'(w);
                    m_last   = w;
                    e_ack[w] = 1'b1;
                    e_xmit   = 1'b1;
                    m_active = 1;
                    m_seen   = 0;
                    m_age    = 0;
                end
            end else begin
                // m_age = edges elapsed since the grant edge
                m_age++;
                if (m_age > 1) begin
                    if (!m_seen) begin
                        if (s_busy) m_seen = 1;
                        else if (m_age == TMO + 1) begin
                            e_err    = 1'b1;
                            m_active = 0;
                        end
                    end else if (!s_busy) begin
                        e_cnt    = e_cnt + 16'd1;
                        m_active = 0;
                    end
                end
            end
            #1;
            chk("uart_transmit", uart_transmit, e_xmit);
            chk("uart_tx_byte", uart_tx_byte, e_byte);
            chk("req_ack", req_ack, e_ack);
            chk("grant_id", grant_id, e_grant);
            chk("busy", busy, m_active);
            chk("start_err", start_err, e_err);
            chk("tx_count", tx_count, e_cnt);
        end
    end

    // ---------------- requesters + UART stub ----------------
    int         reload [NREQ];
    int         ack_log [$];
    logic [7:0] line_q [$];
    int         stub_mode;   // 1: normal uart, 0: never goes busy
    int         stub_rise;
    int         stub_len;
    bit         force_busy;
    int         st_dly;
    int         st_left;
    int         ncyc;
    int         t_xmit;
    int         t_err;
    bit         err_seen;

    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (start_err) begin
            err_seen = 1;
            t_err    = ncyc;
        end
        if (uart_transmit) t_xmit = ncyc;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) begin
                ack_log.push_back(i);
                if (reload[i] > 0) begin
                    reload[i]--;
                    req_byte[8*i +: 8] = req_byte[8*i +: 8] + 8'h11;
                end else begin
                    req[i]      = 1'b0;
                    req_lock[i] = 1'b0;
                end
            end
        end
        if (st_dly > 0) begin
            st_dly--;
            if (st_dly == 0) st_left = stub_len;
        end else if (st_left > 0) begin
            st_left--;
        end
        if (uart_transmit && stub_mode == 1 && st_dly == 0 && st_left == 0) begin
            line_q.push_back(uart_tx_byte);
            if (stub_rise == 0) st_left = stub_len;
            else st_dly = stub_rise;
        end
        uart_is_transmitting = force_busy || (st_left > 0);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy || uart_is_transmitting || req != 0) && n < 400) begin
            tick();
            n++;
        end
        chk(name, n < 400, 1'b1);
    endtask

    initial begin : stim
        int n;
        int exp_lock [4];
        rst_n = 1'b0;
        req = '0;
        req_lock = '0;
        req_byte = '0;
        uart_is_transmitting = 1'b0;
        force_busy = 0;
        stub_mode = 1;
        stub_rise = 0;
        stub_len = 12;
        st_dly = 0;
        st_left = 0;
        ncyc = 0;
        t_xmit = -1;
        t_err = -1;
        err_seen = 0;
        for (int i = 0; i < NREQ; i++) reload[i] = 0;

        repeat (3) tick();
        chk("rst_tx_count", tx_count, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 3'd0);
        chk("rst_xmit", uart_transmit, 1'b0);
        rst_n = 1'b1;
        tick();

        // contention: all four request, each re-presents once
        ack_log.delete();
        line_q.delete();
        for (int i = 0; i < NREQ; i++) reload[i] = 1;
        req_byte = {8'h40, 8'h30, 8'h20, 8'h10};
        req = 4'b1111;
        n = 0;
        while (ack_log.size() < 8 && n < 2000) begin
            tick();
            n++;
        end
        chk("contend_budget", n < 2000, 1'b1);
        wait_quiet("contend_idle");
        for (int i = 0; i < 8; i++)
            chk("contend_order", (i < ack_log.size()) ? ack_log[i] : -1, i % 4);
        chk("contend_count", tx_count, 16'd8);
        chk("contend_lines", line_q.size(), 8);
        chk("contend_line7", (line_q.size() == 8) ? line_q[7] : 8'h00, 8'h51);

        // single request
        line_q.delete();
        req_byte[7:0] = 8'h55;
        req = 4'b0001;
        tick();
        chk("single_ack", req_ack, 4'b0001);
        chk("single_byte", uart_tx_byte, 8'h55);
        chk("single_xmit_on", uart_transmit, 1'b1);
        tick();
        chk("single_xmit_off", uart_transmit, 1'b0);
        wait_quiet("single_idle");
        chk("single_line", (line_q.size() == 1) ? line_q[0] : 8'h00, 8'h55);
        chk("single_count", tx_count, 16'd9);

        // busy seen for one cycle only, then falls
        err_seen = 0;
        stub_rise = 1;
        stub_len = 1;
        req_byte[23:16] = 8'h77;
        req = 4'b0100;
        wait_quiet("fall_idle");
        chk("fall_count", tx_count, 16'd10);
        chk("fall_no_err", err_seen, 1'b0);
        stub_rise = 0;
        stub_len = 12;

        // external busy blocks grant; req[3] abandoned before any ack
        ack_log.delete();
        line_q.delete();
        force_busy = 1;
        uart_is_transmitting = 1'b1;
        req_byte[23:16] = 8'h66;
        req_byte[31:24] = 8'h99;
        req = 4'b1100;
        repeat (5) tick();
        chk("blocked_no_ack", ack_log.size(), 0);
        req[3] = 1'b0;
        tick();
        force_busy = 0;
        uart_is_transmitting = 1'b0;
        tick();
        chk("release_ack", req_ack, 4'b0100);
        wait_quiet("release_idle");
        chk("release_count", tx_count, 16'd11);
        chk("release_line", (line_q.size() == 1) ? line_q[0] : 8'h00, 8'h66);
        chk("release_no_err", err_seen, 1'b0);

        // start timeout: uart never reports busy
        stub_mode = 0;
        t_xmit = -1;
        t_err = -1;
        req_byte[7:0] = 8'hA5;
        req = 4'b0001;
        wait_quiet("tmo_idle");
        chk("tmo_delay", t_err - t_xmit, TMO + 1);
        chk("tmo_count", tx_count, 16'd11);
        chk("tmo_busy", busy, 1'b0);
        stub_mode = 1;

        // asynchronous reset in the middle of a frame
        stub_len = 30;
        req_byte[7:0] = 8'h3C;
        req = 4'b0001;
        repeat (8) tick();
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_xmit", uart_transmit, 1'b0);
        chk("arst_byte", uart_tx_byte, 8'h00);
        chk("arst_ack", req_ack, 4'b0000);
        chk("arst_grant", grant_id, 3'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_err", start_err, 1'b0);
        chk("arst_count", tx_count, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (uart_is_transmitting && n < 100) begin
            tick();
            n++;
        end
        chk("rst_frame_end", n < 100, 1'b1);
        stub_len = 12;
        ack_log.delete();
        req_byte[7:0] = 8'h3D;
        req_byte[15:8] = 8'hC3;
        req = 4'b0011;
        wait_quiet("post_rst_idle");
        chk("post_rst_first", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
        chk("post_rst_second", (ack_log.size() > 1) ? ack_log[1] : -1, 1);
        chk("post_rst_count", tx_count, 16'd2);

        // keep-grant hint: requester 0 has three bytes, requester 1 one
`ifdef ARB_LOCK_EN
        exp_lock = '{0, 0, 0, 1};
`else
        exp_lock = '{0, 1, 0, 0};
`endif
        ack_log.delete();
        reload[0] = 2;
        reload[1] = 0;
        req_byte[7:0] = 8'h01;
        req_byte[15:8] = 8'h02;
        req_lock = 4'b0001;
        req = 4'b0011;
        wait_quiet("lock_idle");
        for (int i = 0; i < 4; i++)
            chk("lock_order", (i < ack_log.size()) ? ack_log[i] : -1, exp_lock[i]);
        chk("lock_count", tx_count, 16'd6);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
